nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps an NCO frequency control word from a start value up to a
// stop value, holding each value for dwell+1 cycles. Supports a single ramp, a
// repeating sawtooth and a continuous triangle. Steps saturate at the sweep
// limits and never wrap around the control-word range.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a configuration; cfg_ready high
// UP    | ramping ctrl upward toward the stop word
// DOWN  | ramping ctrl downward toward the start word (triangle only)
module nco_sweep_ctrl #(
    parameter int N  = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_start,
    input  logic [N-1:0]  cfg_stop,
    input  logic [N-1:0]  cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          abort,
    output logic [N-1:0]  ctrl,
    output logic          nco_rst,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SAW = 2'b01;
    localparam logic [1:0] MODE_TRI = 2'b10;

    state_t        state;
    logic [N-1:0]  start_q;
    logic [N-1:0]  stop_q;
    logic [N-1:0]  step_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    mode_q;
    logic [DW-1:0] dwell_cnt;

    logic [N:0]    up_sum;
    logic [N:0]    dn_diff;
    logic [N-1:0]  up_val;
    logic [N-1:0]  dn_val;
    logic          cfg_bad;

    // Next step values are formed one bit wider so a carry or borrow can be
    // seen and the word clamped to the sweep limit instead of wrapping.
    assign up_sum  = {1'b0, ctrl} + {1'b0, step_q};
    assign dn_diff = {1'b0, ctrl} - {1'b0, step_q};
    assign up_val  = (up_sum[N]  || (up_sum[N-1:0]  >= stop_q))  ? stop_q  : up_sum[N-1:0];
    assign dn_val  = (dn_diff[N] || (dn_diff[N-1:0] <= start_q)) ? start_q : dn_diff[N-1:0];

    assign cfg_bad   = (cfg_stop < cfg_start) || (cfg_step == '0);
    assign cfg_ready = (state == IDLE);

    // Sweep sequencer: configuration handshake, dwell down-counter, stepping
    // and the one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ctrl      <= '0;
            dwell_cnt <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            mode_q    <= '0;
            nco_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            nco_rst <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    // abort has no meaning here; a pending config is still taken
                    if (cfg_valid) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            start_q   <= cfg_start;
                            stop_q    <= cfg_stop;
                            step_q    <= cfg_step;
                            dwell_q   <= cfg_dwell;
                            mode_q    <= cfg_mode;
                            ctrl      <= cfg_start;
                            dwell_cnt <= cfg_dwell;
                            nco_rst   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= UP;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else begin
                        dwell_cnt <= dwell_q;
                        if (ctrl == stop_q) begin
                            case (mode_q)
                                MODE_SAW: begin
                                    ctrl <= start_q;
                                    wrap <= 1'b1;
                                end
                                MODE_TRI: begin
                                    ctrl  <= dn_val;
                                    state <= DOWN;
                                end
                                default: begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            endcase
                        end else begin
                            ctrl <= up_val;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end else begin
                        dwell_cnt <= dwell_q;
                        if (ctrl == start_q) begin
                            ctrl  <= up_val;
                            wrap  <= 1'b1;
                            state <= UP;
                        end else begin
                            ctrl <= dn_val;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: each scenario pushes the expected per-cycle outputs
// into a queue as the configuration is applied, then pops and compares one
// entry per cycle. Entries may also request abort or rst for the next edge.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_stop = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic        abort = 1'b0;
    logic [31:0] ctrl;
    logic        nco_rst, busy, done, wrap, err;

    nco_sweep_ctrl #(.N(32), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .abort     (abort),
        .ctrl      (ctrl),
        .nco_rst   (nco_rst),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    // packed order: ctrl, busy, done, wrap, nco_rst, err, cfg_ready
    typedef struct packed {
        logic [31:0] ctrl;
        logic        busy;
        logic        done;
        logic        wrap;
        logic        nco;
        logic        er;
        logic        ready;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   ab;
        bit   rs;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic px(input logic [31:0] c, input logic b, input logic d, input logic w,
                      input logic n, input logic er = 1'b0, input bit ab = 1'b0, input bit rs = 1'b0);
        ent_t t;
        t.o  = {c, b, d, w, n, er, ~b};
        t.ab = ab;
        t.rs = rs;
        sb.push_back(t);
    endtask

    task automatic hold(input logic [31:0] c, input int k, input bit first_nco);
        for (int i = 0; i < k; i++) px(c, 1'b1, 1'b0, 1'b0, first_nco && (i == 0));
    endtask

    // Called at a falling edge; the following rising edge is the acceptance edge.
    task automatic apply_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                             input logic [15:0] d, input logic [1:0] m);
        cfg_start = s;
        cfg_stop  = p;
        cfg_step  = st;
        cfg_dwell = d;
        cfg_mode  = m;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        ent_t e;
        obs_t obs;
        int   i = 0;
        cfg_start = 32'd1; cfg_stop = 32'd2; cfg_step = 32'd1; cfg_dwell = '0; cfg_mode = '0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 3; k++) px(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        px(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        px(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL reset_release[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    // Single ramp; abort raised together with the configuration must be ignored.
    task automatic test_single;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd100, 3, 1'b1);
        hold(32'd110, 3, 1'b0);
        hold(32'd120, 3, 1'b0);
        hold(32'd130, 3, 1'b0);
        px(32'd130, 1'b0, 1'b1, 1'b0, 1'b0);
        px(32'd130, 1'b0, 1'b0, 1'b0, 1'b0);
        px(32'd130, 1'b0, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        apply_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'b00);
        abort = 1'b0;
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL single[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    task automatic test_clamp;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd0, 1, 1'b1);
        hold(32'd10, 1, 1'b0);
        hold(32'd20, 1, 1'b0);
        hold(32'd25, 1, 1'b0);
        px(32'd25, 1'b0, 1'b1, 1'b0, 1'b0);
        px(32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd0, 32'd25, 32'd10, 16'd0, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL clamp[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        hold(32'hFFFF_FFF0, 1, 1'b1);
        hold(32'hFFFF_FFFF, 1, 1'b0);
        px(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        px(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL overflow[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    task automatic test_triangle;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd0, 1, 1'b1);
        hold(32'd10, 1, 1'b0);
        hold(32'd20, 1, 1'b0);
        hold(32'd10, 1, 1'b0);
        hold(32'd0, 1, 1'b0);
        px(32'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(32'd20, 1, 1'b0);
        hold(32'd10, 1, 1'b0);
        hold(32'd0, 1, 1'b0);
        px(32'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        px(32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        px(32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd0, 32'd20, 32'd10, 16'd0, 2'b10);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL triangle[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    task automatic test_sawtooth;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd5, 2, 1'b1);
        hold(32'd10, 2, 1'b0);
        hold(32'd15, 2, 1'b0);
        px(32'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(32'd5, 1, 1'b0);
        hold(32'd10, 2, 1'b0);
        hold(32'd15, 2, 1'b0);
        px(32'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        px(32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        px(32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd5, 32'd15, 32'd5, 16'd1, 2'b01);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL sawtooth[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    // start == stop in every mode, including mode 11 behaving as a single ramp.
    task automatic test_equal;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd50, 2, 1'b1);
        px(32'd50, 1'b0, 1'b1, 1'b0, 1'b0);
        px(32'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd50, 32'd50, 32'd3, 16'd1, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL equal_single[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        hold(32'd9, 2, 1'b1);
        px(32'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(32'd9, 1, 1'b0);
        px(32'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        px(32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd9, 32'd9, 32'd1, 16'd1, 2'b01);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL equal_saw[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        hold(32'd7, 2, 1'b1);
        px(32'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(32'd7, 1, 1'b0);
        px(32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        px(32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd7, 32'd7, 32'd1, 16'd0, 2'b10);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL equal_tri[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        hold(32'd40, 1, 1'b1);
        px(32'd40, 1'b0, 1'b1, 1'b0, 1'b0);
        px(32'd40, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd40, 32'd40, 32'd1, 16'd0, 2'b11);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL mode3[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    // Runs right after test_equal, so ctrl is sitting at 40 while idle.
    task automatic test_reject;
        ent_t e;
        obs_t obs;
        int   i = 0;
        px(32'd40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        px(32'd40, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd20, 32'd10, 32'd1, 16'd0, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL reject_order[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        px(32'd40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        px(32'd40, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd5, 32'd100, 32'd0, 16'd0, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL reject_step[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    task automatic test_abort_rst;
        ent_t e;
        obs_t obs;
        int   i = 0;
        hold(32'd100, 3, 1'b1);
        px(32'd110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) px(32'd110, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL abort[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
        hold(32'd100, 3, 1'b1);
        px(32'd110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) px(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_cfg(32'd100, 32'd130, 32'd10, 16'd2, 2'b00);
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            obs = {ctrl, busy, done, wrap, nco_rst, err, cfg_ready};
            n_cmp++;
            if (obs !== e.o) begin
                n_bad++;
                $display("FAIL midrst[%0d] got=%h exp=%h", i, obs, e.o);
            end
            abort = e.ab; rst = e.rs; i++;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_clamp;
        test_triangle;
        test_sawtooth;
        test_equal;
        test_reject;
        test_abort_rst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
